// File: rtl/alu_dispatch.sv
// CU-side ALU request initiator: decodes one operation, drives the ALU bus,
// waits for ALU_ready (bounded by TIMEOUT) and returns the result.
module alu_dispatch #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        soc_clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_dat1,
   input  logic [31:0] req_dat2,
   input  logic [2:0]  req_funct3,
   input  logic        req_alt,
   input  logic        req_optype,
   input  logic [4:0]  req_rd,
   output logic        dat_ready,
   output logic [31:0] ALU_dat1,
   output logic [31:0] ALU_dat2,
   output logic [2:0]  ALU_opcode,
   output logic        ALU_opcode_differentiator,
   output logic        ALU_optype,
   output logic [4:0]  Instruction_to_ALU,
   input  logic [31:0] ALU_out,
   input  logic        ALU_overflow,
   input  logic        ALU_con_met,
   input  logic        ALU_zero,
   input  logic        ALU_ready,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [4:0]  rsp_rd,
   output logic        rsp_con_met,
   output logic        rsp_overflow,
   output logic        rsp_zero,
   output logic        rsp_err
);

   typedef enum logic [1:0] {IDLE, SETUP, WAIT, RESP} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [4:0]       ILLEGAL = 5'd16;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [4:0]       req_code;
   logic             req_legal;
   logic             tmo;

   function automatic logic [4:0] decode(
      input logic       opt,
      input logic       alt,
      input logic [2:0] f3
   );
      logic [4:0] c;
      c = ILLEGAL;
      unique case ({opt, alt, f3})
         5'b10000: c = 5'd0;
         5'b10001: c = 5'd1;
         5'b10100: c = 5'd2;
         5'b10101: c = 5'd3;
         5'b10110: c = 5'd4;
         5'b10111: c = 5'd5;
         5'b00000: c = 5'd6;
         5'b01000: c = 5'd7;
         5'b00001: c = 5'd8;
         5'b00010: c = 5'd9;
         5'b00011: c = 5'd10;
         5'b00100: c = 5'd11;
         5'b00101: c = 5'd12;
         5'b01101: c = 5'd13;
         5'b00110: c = 5'd14;
         5'b00111: c = 5'd15;
         default:  c = ILLEGAL;
      endcase
      return c;
   endfunction

   assign req_code  = decode(req_optype, req_alt, req_funct3);
   assign req_legal = (req_code != ILLEGAL);
   assign tmo       = (cnt == LAST);
   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);

   always_ff @(posedge soc_clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (req_valid) state_nxt = req_legal ? SETUP : RESP;
         SETUP:   state_nxt = WAIT;
         WAIT:    if (ALU_ready || tmo) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ALU bus registers double as the request latches; illegal ops leave them alone
   always_ff @(posedge soc_clk or posedge reset) begin
      if (reset) begin
         cnt                       <= '0;
         dat_ready                 <= 1'b0;
         ALU_dat1                  <= '0;
         ALU_dat2                  <= '0;
         ALU_opcode                <= '0;
         ALU_opcode_differentiator <= 1'b0;
         ALU_optype                <= 1'b0;
         Instruction_to_ALU        <= '0;
         rsp_data                  <= '0;
         rsp_rd                    <= '0;
         rsp_con_met               <= 1'b0;
         rsp_overflow              <= 1'b0;
         rsp_zero                  <= 1'b0;
         rsp_err                   <= 1'b0;
      end else begin
         if (state == IDLE && req_valid) begin
            rsp_rd <= req_rd;
            if (req_legal) begin
               ALU_dat1                  <= req_dat1;
               ALU_dat2                  <= req_dat2;
               ALU_opcode                <= req_funct3;
               ALU_opcode_differentiator <= req_alt;
               ALU_optype                <= req_optype;
               Instruction_to_ALU        <= req_code;
            end else begin
               rsp_data     <= '0;
               rsp_con_met  <= 1'b0;
               rsp_overflow <= 1'b0;
               rsp_zero     <= 1'b0;
               rsp_err      <= 1'b1;
            end
         end
         if (state == SETUP) begin
            dat_ready <= 1'b1;
            cnt       <= '0;
         end
         if (state == WAIT) begin
            cnt <= cnt + 1'b1;
            if (ALU_ready) begin
               dat_ready    <= 1'b0;
               rsp_data     <= ALU_out;
               rsp_con_met  <= ALU_con_met;
               rsp_overflow <= ALU_overflow;
               rsp_zero     <= ALU_zero;
               rsp_err      <= 1'b0;
            end else if (tmo) begin
               dat_ready    <= 1'b0;
               rsp_data     <= '0;
               rsp_con_met  <= 1'b0;
               rsp_overflow <= 1'b0;
               rsp_zero     <= 1'b0;
               rsp_err      <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: vector table with an ALU responder model,
// expected responses queued at issue and compared on handshake.
module tb_alu_dispatch;

   logic        soc_clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_dat1;
   logic [31:0] req_dat2;
   logic [2:0]  req_funct3;
   logic        req_alt;
   logic        req_optype;
   logic [4:0]  req_rd;
   logic        dat_ready;
   logic [31:0] ALU_dat1;
   logic [31:0] ALU_dat2;
   logic [2:0]  ALU_opcode;
   logic        ALU_opcode_differentiator;
   logic        ALU_optype;
   logic [4:0]  Instruction_to_ALU;
   logic [31:0] ALU_out;
   logic        ALU_overflow;
   logic        ALU_con_met;
   logic        ALU_zero;
   logic        ALU_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [4:0]  rsp_rd;
   logic        rsp_con_met;
   logic        rsp_overflow;
   logic        rsp_zero;
   logic        rsp_err;

   alu_dispatch #(.TIMEOUT(16), .CNT_W(5)) dut (
      .soc_clk(soc_clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_dat1(req_dat1),
      .req_dat2(req_dat2),
      .req_funct3(req_funct3),
      .req_alt(req_alt),
      .req_optype(req_optype),
      .req_rd(req_rd),
      .dat_ready(dat_ready),
      .ALU_dat1(ALU_dat1),
      .ALU_dat2(ALU_dat2),
      .ALU_opcode(ALU_opcode),
      .ALU_opcode_differentiator(ALU_opcode_differentiator),
      .ALU_optype(ALU_optype),
      .Instruction_to_ALU(Instruction_to_ALU),
      .ALU_out(ALU_out),
      .ALU_overflow(ALU_overflow),
      .ALU_con_met(ALU_con_met),
      .ALU_zero(ALU_zero),
      .ALU_ready(ALU_ready),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data(rsp_data),
      .rsp_rd(rsp_rd),
      .rsp_con_met(rsp_con_met),
      .rsp_overflow(rsp_overflow),
      .rsp_zero(rsp_zero),
      .rsp_err(rsp_err)
   );

   always #5 soc_clk = ~soc_clk;

   typedef struct {
      bit        opt;
      bit        alt;
      bit [2:0]  f3;
      bit [31:0] d1;
      bit [31:0] d2;
      bit [4:0]  rd;
      int        delay;
      int        bp;
      bit [31:0] aout;
      bit        aovf;
      bit        acon;
      bit        azero;
      bit [4:0]  e_instr;
      bit        e_err;
      bit [31:0] e_data;
      bit        e_ovf;
      bit        e_con;
      bit        e_zero;
      int        e_hi;
   } vec_t;

   typedef struct {
      bit [31:0] data;
      bit [4:0]  rd;
      bit        err;
      bit        ovf;
      bit        con;
      bit        zero;
   } exp_t;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   vec_t tbl[14];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      exp_t e;
      exp_t got;
      exp_t snap;
      bit   seen;
      bit   done;
      bit   unstable;
      bit   rr_bad;
      int   hi;
      int   first_hi;
      int   rsp_cyc;
      int   bp_left;
      chk($sformatf("v%0d_req_ready_idle", idx), 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_optype = v.opt;
      req_alt    = v.alt;
      req_funct3 = v.f3;
      req_dat1   = v.d1;
      req_dat2   = v.d2;
      req_rd     = v.rd;
      e = '{v.e_data, v.rd, v.e_err, v.e_ovf, v.e_con, v.e_zero};
      sb.push_back(e);
      seen = 0; done = 0; unstable = 0; rr_bad = 0;
      hi = 0; first_hi = 0; rsp_cyc = 0; bp_left = v.bp;
      for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
         @(negedge soc_clk);
         req_valid = 1'b0;
         if (dat_ready) begin
            hi++;
            if (hi == 1) begin
               first_hi = cyc;
               chk($sformatf("v%0d_instr", idx), 32'(Instruction_to_ALU),
                   32'(v.e_instr));
               chk($sformatf("v%0d_alu_dat1", idx), ALU_dat1, v.d1);
               chk($sformatf("v%0d_alu_dat2", idx), ALU_dat2, v.d2);
            end
            if (v.delay != 0 && hi == v.delay) begin
               ALU_ready    = 1'b1;
               ALU_out      = v.aout;
               ALU_overflow = v.aovf;
               ALU_con_met  = v.acon;
               ALU_zero     = v.azero;
            end
         end else begin
            ALU_ready = 1'b0;
         end
         if (rsp_valid) begin
            if (req_ready) rr_bad = 1;
            if (!seen) begin
               seen    = 1;
               rsp_cyc = cyc;
               snap = '{rsp_data, rsp_rd, rsp_err, rsp_overflow,
                        rsp_con_met, rsp_zero};
            end else if (rsp_data !== snap.data || rsp_rd !== snap.rd ||
                         rsp_err !== snap.err || rsp_zero !== snap.zero ||
                         rsp_overflow !== snap.ovf ||
                         rsp_con_met !== snap.con) begin
               unstable = 1;
            end
            if (bp_left == 0) begin
               got = sb.pop_front();
               chk($sformatf("v%0d_rsp_data", idx), rsp_data, got.data);
               chk($sformatf("v%0d_rsp_rd", idx), 32'(rsp_rd), 32'(got.rd));
               chk($sformatf("v%0d_rsp_err", idx), 32'(rsp_err),
                   32'(got.err));
               chk($sformatf("v%0d_rsp_flags", idx),
                   32'({rsp_overflow, rsp_con_met, rsp_zero}),
                   32'({got.ovf, got.con, got.zero}));
               rsp_ready = 1'b1;
               done = 1;
            end else begin
               bp_left--;
            end
         end
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL v%0d_rsp_timeout actual=none required=rsp_valid",
                  idx);
         void'(sb.pop_front());
      end else begin
         @(negedge soc_clk);
         rsp_ready = 1'b0;
         ALU_ready = 1'b0;
         chk($sformatf("v%0d_rsp_valid_drop", idx), 32'(rsp_valid), 32'd0);
      end
      chk($sformatf("v%0d_dat_ready_cycles", idx), 32'(hi), 32'(v.e_hi));
      chk($sformatf("v%0d_first_hi", idx), 32'(first_hi),
          (v.e_hi == 0) ? 32'd0 : 32'd2);
      chk($sformatf("v%0d_rsp_latency", idx), 32'(rsp_cyc),
          (v.e_hi == 0) ? 32'd1 : 32'(2 + v.e_hi));
      chk($sformatf("v%0d_rsp_stable", idx), 32'(unstable), 32'd0);
      chk($sformatf("v%0d_req_ready_busy", idx), 32'(rr_bad), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // opt alt f3 d1 d2 rd delay bp | aout ovf con zero | instr err data ovf con zero hi
      tbl[0]  = '{1'b0, 1'b0, 3'b000, 32'd5, 32'd7, 5'd3, 4, 0,
                  32'd12, 1'b0, 1'b0, 1'b0,
                  5'd6, 1'b0, 32'd12, 1'b0, 1'b0, 1'b0, 4};
      tbl[1]  = '{1'b0, 1'b1, 3'b000, 32'h80000000, 32'd1, 5'd4, 2, 0,
                  32'h7FFFFFFF, 1'b1, 1'b0, 1'b0,
                  5'd7, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 2};
      tbl[2]  = '{1'b1, 1'b0, 3'b100, 32'd3, 32'd9, 5'd5, 3, 0,
                  32'd0, 1'b0, 1'b1, 1'b1,
                  5'd2, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 3};
      tbl[3]  = '{1'b0, 1'b1, 3'b010, 32'd1, 32'd2, 5'd6, 1, 0,
                  32'hDEADBEEF, 1'b1, 1'b1, 1'b1,
                  5'd16, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 0};
      tbl[4]  = '{1'b0, 1'b0, 3'b000, 32'd1, 32'd1, 5'd7, 0, 0,
                  32'd0, 1'b0, 1'b0, 1'b0,
                  5'd6, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 16};
      tbl[5]  = '{1'b0, 1'b0, 3'b100, 32'hAAAA0000, 32'h0000FFFF, 5'd8, 1, 0,
                  32'hAAAAFFFF, 1'b0, 1'b0, 1'b0,
                  5'd11, 1'b0, 32'hAAAAFFFF, 1'b0, 1'b0, 1'b0, 1};
      tbl[6]  = '{1'b0, 1'b1, 3'b101, 32'hF0000000, 32'd4, 5'd9, 2, 5,
                  32'hFF000000, 1'b0, 1'b0, 1'b0,
                  5'd13, 1'b0, 32'hFF000000, 1'b0, 1'b0, 1'b0, 2};
      tbl[7]  = '{1'b1, 1'b1, 3'b000, 32'd1, 32'd1, 5'd10, 1, 0,
                  32'd1, 1'b0, 1'b1, 1'b0,
                  5'd16, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 0};
      tbl[8]  = '{1'b1, 1'b0, 3'b010, 32'd1, 32'd1, 5'd11, 1, 0,
                  32'd1, 1'b0, 1'b1, 1'b0,
                  5'd16, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 0};
      tbl[9]  = '{1'b0, 1'b0, 3'b111, 32'hFF00FF00, 32'h0F0F0F0F, 5'd12, 16, 0,
                  32'h0F000F00, 1'b0, 1'b0, 1'b0,
                  5'd15, 1'b0, 32'h0F000F00, 1'b0, 1'b0, 1'b0, 16};
      tbl[10] = '{1'b1, 1'b0, 3'b111, 32'd5, 32'd5, 5'd13, 1, 0,
                  32'd0, 1'b0, 1'b1, 1'b1,
                  5'd5, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1};
      tbl[11] = '{1'b0, 1'b0, 3'b011, 32'd1, 32'd2, 5'd14, 5, 0,
                  32'd1, 1'b0, 1'b0, 1'b0,
                  5'd10, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0, 5};
      tbl[12] = '{1'b0, 1'b0, 3'b101, 32'h80000000, 32'd31, 5'd15, 1, 1,
                  32'd1, 1'b0, 1'b0, 1'b0,
                  5'd12, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0, 1};
      tbl[13] = '{1'b0, 1'b1, 3'b001, 32'd1, 32'd1, 5'd16, 1, 0,
                  32'd1, 1'b0, 1'b0, 1'b0,
                  5'd16, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 0};

      reset = 1'b1;
      req_valid = 1'b0; req_dat1 = '0; req_dat2 = '0; req_funct3 = '0;
      req_alt = 1'b0; req_optype = 1'b0; req_rd = '0;
      ALU_out = '0; ALU_overflow = 1'b0; ALU_con_met = 1'b0;
      ALU_zero = 1'b0; ALU_ready = 1'b0; rsp_ready = 1'b0;
      repeat (3) @(negedge soc_clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_dat_ready", 32'(dat_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_instr", 32'(Instruction_to_ALU), 32'd0);
      chk("rst_alu_bus", ALU_dat1 | ALU_dat2 |
          32'({ALU_opcode, ALU_opcode_differentiator, ALU_optype}), 32'd0);
      chk("rst_rsp_bus", rsp_data | 32'({rsp_rd, rsp_err, rsp_zero,
          rsp_overflow, rsp_con_met}), 32'd0);
      reset = 1'b0;

      // stray ALU_ready while idle must not produce a response
      ALU_ready = 1'b1; ALU_out = 32'h12345678;
      repeat (3) @(negedge soc_clk);
      chk("idle_alu_ready_rsp", 32'(rsp_valid), 32'd0);
      chk("idle_alu_ready_dat", 32'(dat_ready), 32'd0);
      ALU_ready = 1'b0;
      @(negedge soc_clk);

      for (int i = 0; i < 14; i++) run_vec(i, tbl[i]);

      // reset during WAIT discards the operation
      req_valid = 1'b1; req_optype = 1'b0; req_alt = 1'b0;
      req_funct3 = 3'b000; req_dat1 = 32'd9; req_dat2 = 32'd9; req_rd = 5'd1;
      @(negedge soc_clk);
      req_valid = 1'b0;
      repeat (2) @(negedge soc_clk);
      chk("mid_dat_ready_high", 32'(dat_ready), 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_dat_ready", 32'(dat_ready), 32'd0);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
      @(negedge soc_clk);
      reset = 1'b0;
      @(negedge soc_clk);
      chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      run_vec(100, tbl[0]);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
- CU-side initiator for the ALU request/ready protocol.
- Accepts one decoded operation from the IDU/CU pipeline via a valid/ready handshake, decodes {optype, alt, funct3} into the 5-bit ALU instruction code, and drives the ALU operand/opcode bus and dat_ready.
- Waits for ALU_ready, captures the result and flags, and presents them to writeback/branch logic on a valid/ready response port.
- Illegal opcodes and ALU timeouts are reported with an error flag.

Parameters:
- TIMEOUT, 16, max cycles dat_ready is held high waiting for ALU_ready before aborting with error.
- CNT_W, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
- soc_clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_dat1  in  32  rs1 operand
- req_dat2  in  32  rs2 or immediate operand
- req_funct3  in  3  instruction [14:12]
- req_alt  in  1  SUB/SRA/SRAI differentiator
- req_optype  in  1  1 = B type, 0 = I/R type
- req_rd  in  5  destination tag, returned unchanged
- dat_ready  out  1  request strobe to ALU, level, held until ALU_ready sampled
- ALU_dat1  out  32  operand 1 to ALU
- ALU_dat2  out  32  operand 2 to ALU
- ALU_opcode  out  3  funct3 to ALU
- ALU_opcode_differentiator  out  1  alt to ALU
- ALU_optype  out  1  optype to ALU
- Instruction_to_ALU  out  5  decoded op code, 0..16
- ALU_out  in  32  ALU result
- ALU_overflow  in  1  ALU overflow flag
- ALU_con_met  in  1  ALU branch/compare flag
- ALU_zero  in  1  ALU zero flag
- ALU_ready  in  1  ALU result valid
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  captured result
- rsp_rd  out  5  tag of the request
- rsp_con_met, rsp_overflow, rsp_zero  out  1 each  captured flags
- rsp_err  out  1  illegal op or timeout

Behaviour:
- Reset (async): state IDLE, timeout counter 0; every output 0 except req_ready = 1 (asserted in IDLE); Instruction_to_ALU = 0.
- Decode is combinational on the latched request:
  - optype=1, alt=0: funct3 000→0 (BEQ), 001→1 (BNE), 100→2 (BLT), 101→3 (BGE), 110→4 (BLTU), 111→5 (BGEU).
  - optype=0: 000/alt0→6 (ADD), 000/alt1→7 (SUB), 001→8 (SLL), 010→9 (SLT), 011→10 (SLTU), 100→11 (XOR), 101/alt0→12 (SRL), 101/alt1→13 (SRA), 110→14 (OR), 111→15 (AND).
  - alt=1 is legal only for funct3 000 and 101 when optype=0. Every other combination decodes to 16 (illegal).
- FSM:
  - IDLE: req_ready=1. On req_valid, latch all req_* fields at the edge. Decode 16 → RESP with rsp_err=1, rsp_data=0, flags 0, dat_ready never raised. Otherwise → SETUP.
  - SETUP (1 cycle): ALU_dat1/2, opcode, differentiator, optype and Instruction_to_ALU driven from the latches; dat_ready=0. This guarantees operands are stable one full cycle before the dat_ready rising edge. → WAIT.
  - WAIT: dat_ready=1 (registered); counter increments each cycle.
    - If ALU_ready=1 is sampled: capture ALU_out, ALU_con_met, ALU_overflow, ALU_zero into rsp_*; rsp_err=0; dat_ready drops at the same edge; → RESP.
    - Else, if the counter reaches TIMEOUT: dat_ready drops, rsp_data=0, rsp_err=1, → RESP.
    - ALU_ready wins if it coincides with the terminal count.
  - RESP: rsp_valid=1; rsp_* held stable until rsp_ready=1 is sampled. Then rsp_valid=0, → IDLE.
- req_ready=0 outside IDLE; one request in flight at most.
- ALU bus outputs hold their last value after WAIT. dat_ready is low for at least two cycles (RESP + SETUP) between operations, so ALU_ready falls before the next issue.
- ALU_ready sampled high in any state other than WAIT is ignored.
- Latency: if ALU_ready is first sampled high in cycle t, rsp_valid is high from cycle t+1. Illegal op: rsp_valid in the cycle after acceptance.
- Reset mid-operation: immediate return to IDLE, dat_ready=0, any pending response discarded.

Test Plan:
- ADD: dat1=5, dat2=7, funct3=000, alt=0, optype=0, rd=3; ALU model returns 12 four cycles after dat_ready rises.
  - Instruction_to_ALU=6, dat_ready rises two cycles after acceptance.
  - rsp_data=12, rsp_rd=3, rsp_err=0.
- SUB overflow: dat1=0x80000000, dat2=1, alt=1; model returns 0x7FFFFFFF with overflow=1.
  - Instruction_to_ALU=7, rsp_overflow=1, rsp_data=0x7FFFFFFF.
- BLT: optype=1, funct3=100; model returns con_met=1, out=0.
  - Instruction_to_ALU=2, rsp_con_met=1.
- Illegal: optype=0, funct3=010, alt=1.
  - dat_ready never asserts; rsp_valid next cycle with rsp_err=1, rsp_data=0.
- Timeout: ALU_ready tied 0.
  - dat_ready high exactly TIMEOUT=16 cycles, then rsp_err=1.
  - Next request is accepted normally.
- Backpressure and reset:
  - rsp_ready=0 for 5 cycles: rsp_* stable, req_ready=0; completes when rsp_ready=1.
  - Separately, reset asserted during WAIT: dat_ready=0, rsp_valid=0, req_ready=1 immediately.
